// File: rtl/alu_display_pkg.sv
// Shared types and constants for the ALU result display.
// FSM encoding, 7-segment codes and the double-dabble step.
package alu_display_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      UPDATE  = 2'd2
   } state_t;

   localparam int DIGITS = 2;
   localparam int BIN_W  = 6;
   localparam logic [2:0] STEP_LAST = 3'd5;

   // active-low {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

   // One double-dabble iteration: adjust digits, then shift.
   function automatic logic [13:0] dabble_step(
      input logic [7:0]       bcd,
      input logic [BIN_W-1:0] bin
   );
      logic [7:0] adj;
      adj = {add3(bcd[7:4]), add3(bcd[3:0])};
      return {adj[6:0], bin, 1'b0};
   endfunction

endpackage

// File: rtl/alu_result_display_if.sv
// Capture bus between the ALU and the result display.
// The master presents result/carry with a load strobe.
interface alu_result_display_if;
   logic [5:0] result;
   logic       carry;
   logic       load;
   logic       busy;

   modport master (
      output result,
      output carry,
      output load,
      input  busy
   );

   modport slave (
      input  result,
      input  carry,
      input  load,
      output busy
   );
endinterface

// File: rtl/alu_result_display_decode.sv
// Combinational 4-bit digit to active-low 7-segment decoder.
// Codes 10-15 turn every segment off.
module seven_seg_decode
   import alu_display_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg_n
);

   always_comb begin
      seg_n = SEG_BLANK;
      unique case (digit)
         4'd0:    seg_n = SEG_0;
         4'd1:    seg_n = SEG_1;
         4'd2:    seg_n = SEG_2;
         4'd3:    seg_n = SEG_3;
         4'd4:    seg_n = SEG_4;
         4'd5:    seg_n = SEG_5;
         4'd6:    seg_n = SEG_6;
         4'd7:    seg_n = SEG_7;
         4'd8:    seg_n = SEG_8;
         4'd9:    seg_n = SEG_9;
         default: seg_n = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/alu_result_display.sv
// Captures a 6-bit ALU result, converts it to BCD, scans 2 digits.
// Define ALU_DISPLAY_CARRY_EN to show the carry on the units dp.
module alu_result_display
   import alu_display_pkg::*;
#(
   parameter int REFRESH_BITS = 16
) (
   input  logic              bbclk,
   input  logic              rst,
   alu_result_display_if.slave alu,
   output logic [6:0]        seg_n,
   output logic [DIGITS-1:0] an_n,
   output logic              dp_n
);

   state_t state_q;
   state_t state_d;

   logic [BIN_W-1:0]        bin_q;
   logic [7:0]              bcd_q;
   logic [2:0]              step_q;
   logic [3:0]              tens_q;
   logic [3:0]              units_q;
   logic                    busy_q;
   logic [REFRESH_BITS-1:0] scan_q;

   logic       accept;
   logic       tens_slot;
   logic       tens_zero;
   logic [3:0] digit;

   assign accept = (state_q == IDLE) && alu.load;

   always_ff @(posedge bbclk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (alu.load) state_d = CONVERT;
         CONVERT: if (step_q == STEP_LAST) state_d = UPDATE;
         UPDATE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge bbclk) begin
      if (rst) begin
         bin_q   <= '0;
         bcd_q   <= '0;
         step_q  <= '0;
         tens_q  <= '0;
         units_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         busy_q <= (state_q != IDLE);
         if (accept) begin
            bin_q  <= alu.result;
            bcd_q  <= '0;
            step_q <= '0;
         end else if (state_q == CONVERT) begin
            {bcd_q, bin_q} <= dabble_step(bcd_q, bin_q);
            step_q         <= step_q + 3'd1;
         end
         if (state_q == UPDATE) begin
            tens_q  <= bcd_q[7:4];
            units_q <= bcd_q[3:0];
         end
      end
   end

   always_ff @(posedge bbclk) begin
      if (rst) scan_q <= '0;
      else     scan_q <= scan_q + 1'b1;
   end

   assign alu.busy  = busy_q;
   assign tens_slot = scan_q[REFRESH_BITS-1];
   assign tens_zero = (tens_q == 4'd0);

   // A blanked tens slot feeds an out-of-range code so the decoder darkens it.
   always_comb begin
      digit = units_q;
      an_n  = 2'b10;
      if (tens_slot) begin
         digit = tens_zero ? 4'hF : tens_q;
         an_n  = tens_zero ? 2'b11 : 2'b01;
      end
   end

   seven_seg_decode u_decode (
      .digit (digit),
      .seg_n (seg_n)
   );

`ifdef ALU_DISPLAY_CARRY_EN
   logic carry_cap_q;
   logic carry_q;

   always_ff @(posedge bbclk) begin
      if (rst) begin
         carry_cap_q <= 1'b0;
         carry_q     <= 1'b0;
      end else begin
         if (accept)             carry_cap_q <= alu.carry;
         if (state_q == UPDATE)  carry_q     <= carry_cap_q;
      end
   end

   assign dp_n = ~(carry_q & ~tens_slot);
`else
   logic unused_carry;
   assign unused_carry = alu.carry;
   assign dp_n         = 1'b1;
`endif

endmodule

// File: doc/alu_result_display.md
ALU_RESULT_DISPLAY -- requirements
Module: alu_result_display

Interface
REQ-001 SHALL have parameter REFRESH_BITS, default 16, giving the width of the digit-scan counter.
REQ-002 SHALL have port bbclk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port result, input, 6 bits, the unsigned ALU result (ALU op_out).
REQ-005 SHALL have port carry, input, 1 bit, the ALU carry_out.
REQ-006 SHALL have port load, input, 1 bit, a one-cycle strobe requesting capture of result/carry.
REQ-007 SHALL have port busy, output, 1 bit, high while a capture is being converted.
REQ-008 SHALL have port seg_n, output, 7 bits, active-low segments {g,f,e,d,c,b,a}.
REQ-009 SHALL have port an_n, output, 2 bits, active-low digit enables: [0] units, [1] tens.
REQ-010 SHALL have port dp_n, output, 1 bit, active-low decimal point.

Function
REQ-011 SHALL use FSM states IDLE, CONVERT and UPDATE, with busy = (state != IDLE), registered.
REQ-012 SHALL, on load=1 in IDLE, capture result and carry and enter CONVERT on that edge.
REQ-013 SHALL ignore load while busy: no capture, no effect on the conversion in flight.
REQ-014 SHALL perform a double-dabble binary-to-BCD conversion in CONVERT, one bit per cycle, for exactly 6 cycles, into 4-bit tens and units.
REQ-015 SHALL move from CONVERT to UPDATE, and in UPDATE write the tens, units and carry display registers, then return to IDLE.
REQ-016 SHALL make the new digits visible on the 7th rising edge after the accepting edge; busy SHALL fall on the 8th.
REQ-017 SHALL hold the display registers stable at all times except in UPDATE.
REQ-018 SHALL run a free-running REFRESH_BITS-wide scan counter that wraps to 0.
REQ-019 SHALL select the units digit when the counter MSB=0 (an_n=2'b10) and the tens digit when MSB=1 (an_n=2'b01).
REQ-020 SHALL blank the tens digit (an_n=2'b11) when tens=0.
REQ-021 SHALL decode digits 0-9 to standard 7-segment codes and drive all segments off (7'b1111111) for codes 10-15.

Reset
REQ-022 SHALL, on rst=1 at a clock edge, set state IDLE, busy 0, digits 0, stored carry 0 and scan counter 0, giving seg_n=7'b1000000, an_n=2'b10 and dp_n=1.
REQ-023 SHALL abort any conversion in progress on rst and discard the partial result.
REQ-024 SHALL give rst priority over load on the same edge.

Configuration
REQ-025 SHALL, when macro ALU_DISPLAY_CARRY_EN is defined, drive dp_n=0 during the units slot if the stored carry=1, and dp_n=1 otherwise.
REQ-026 SHALL, when ALU_DISPLAY_CARRY_EN is undefined, tie dp_n to 1, leave carry unused and omit the carry register.

Structure
REQ-027 SHALL place the FSM state encoding, the segment code constants (SEG_0..SEG_9, SEG_BLANK) and the digit count in shared package alu_display_pkg.
REQ-028 SHALL contain one combinational sub-module, seven_seg_decode (4-bit digit in, 7-bit seg_n out), instantiated once on the muxed digit.

Verification (bench uses REFRESH_BITS=4)
REQ-029 SHALL check: assert rst for 2 cycles -> busy=0, an_n=2'b10, seg_n=7'b1000000, dp_n=1.
REQ-030 SHALL check: load with result=63 -> busy=1 for 7 cycles; then units slot seg_n=7'b0110000 (3) and tens slot seg_n=7'b0000010 (6).
REQ-031 SHALL check: load with result=5 -> tens slot an_n=2'b11; units slot seg_n=7'b0010010.
REQ-032 SHALL check: load result=21, then load result=42 three cycles later -> display shows 21, with tens seg_n=7'b0100100 and units seg_n=7'b1111001.
REQ-033 SHALL check: load with result=12 and carry=1 -> with ALU_DISPLAY_CARRY_EN, dp_n=0 in the units slot and 1 in the tens slot; without the macro, dp_n=1 always.
REQ-034 SHALL check: rst asserted on the 3rd CONVERT cycle of result=63 -> display 0 and busy=0; a subsequent load of 9 then shows units seg_n=7'b0010000.
